// File: rtl/accum_pkg.sv
// accum_pkg
//  Shared types and constants for the accumulator bank.
//  - state_t   : drain sequencer state (IDLE / DRAIN)
//  - ch_width  : channel-index width for a given channel count
//  - DEF_*     : default parameter values used by accum_bank
//  Build option: ACCUM_SATURATE_EN (see accum_lane).
package accum_pkg;

  localparam int DEF_IN_W       = 4;
  localparam int DEF_ACC_W      = 16;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_DUMP_CLEAR = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // A channel index is never narrower than one bit, even for two channels.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// accum_lane
//  One accumulator channel: holds the running total and its sticky overflow.
//  Priority: clear > load > add (clear only happens while draining, load/add
//  only while idle, so they never actually collide).
//  Ports:
//   clk, Rst        clock, synchronous active-high reset
//   add_en          add zero-extended in_data to the total
//   ld_en           replace the total with ld_data, clear overflow
//   clr_en          zero total and overflow (drain with clear)
//   in_data         sample, IN_W bits unsigned
//   ld_data         load value, ACC_W bits
//   acc             current total
//   ovf             sticky overflow
//  Build option: ACCUM_SATURATE_EN -- on carry-out the total clamps to
//  all-ones instead of wrapping modulo 2^ACC_W.
module accum_lane
  import accum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             add_en,
  input  logic             ld_en,
  input  logic             clr_en,
  input  logic [IN_W-1:0]  in_data,
  input  logic [ACC_W-1:0] ld_data,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] add_val;

  // One extra bit so the carry-out is visible as sum[ACC_W].
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};

`ifdef ACCUM_SATURATE_EN
  assign add_val = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign add_val = sum[ACC_W-1:0];
`endif

  // Total and sticky flag; overflow only ever sets on add, clears on load/clear.
  always_ff @(posedge clk) begin
    if (Rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr_en) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (ld_en) begin
      acc <= ld_data;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= add_val;
      if (sum[ACC_W]) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/accum_bank.sv
// accum_bank
//  Bank of CHANNELS independent accumulators fed by a valid/ready sample port,
//  plus a drain sequencer that streams every channel total out in channel
//  order through a valid/ready output port.
//  Ports:
//   clk, Rst           clock, synchronous active-high reset
//   in_valid/in_ready  sample/load handshake (ready only while idle)
//   in_ch              target channel; indices >= CHANNELS are dropped
//   in_data            sample to add (unsigned, zero-extended)
//   ld_en, ld_data     load ld_data instead of adding
//   dump_req           start a drain (only looked at while idle)
//   dump_busy          drain in progress
//   out_valid/out_ready drain beat handshake
//   out_ch, out_data, out_ovf  channel, total and sticky flag of the beat
//   ovf_sticky         per-channel sticky overflow
//  Build option: ACCUM_SATURATE_EN selects saturating instead of wrapping adds.
module accum_bank
  import accum_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DUMP_CLEAR = DEF_DUMP_CLEAR,
  localparam int CH_W      = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [IN_W-1:0]     in_data,
  input  logic                ld_en,
  input  logic [ACC_W-1:0]    ld_data,
  input  logic                dump_req,
  output logic                dump_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_ovf,
  output logic [CHANNELS-1:0] ovf_sticky
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CH_W-1:0]     drain_ch;
  logic                accept;
  logic                beat_take;
  logic                last_beat;
  logic [CHANNELS-1:0] add_sel;
  logic [CHANNELS-1:0] ld_sel;
  logic [CHANNELS-1:0] clr_sel;
  logic [ACC_W-1:0]    acc [CHANNELS];

  assign accept    = in_valid & in_ready;
  assign beat_take = out_valid & out_ready;
  assign last_beat = (drain_ch == LAST_CH);
  assign out_ch    = drain_ch;

  // State register.
  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a drain ends once the last channel's beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dump_req) state_nxt = DRAIN;
      DRAIN: if (beat_take && last_beat) state_nxt = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    dump_busy = (state == DRAIN);
    out_valid = (state == DRAIN);
  end

  // Drain pointer walks the channels and parks at 0 between drains, so a new
  // drain always starts with channel 0.
  always_ff @(posedge clk) begin
    if (Rst)            drain_ch <= '0;
    else if (beat_take) drain_ch <= last_beat ? '0 : drain_ch + CH_W'(1);
  end

  // Per-lane strobes. Exact index match means out-of-range channels select
  // nothing and are silently dropped.
  always_comb begin
    add_sel = '0;
    ld_sel  = '0;
    clr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      add_sel[i] = accept && !ld_en && (in_ch == CH_W'(i));
      ld_sel[i]  = accept &&  ld_en && (in_ch == CH_W'(i));
      clr_sel[i] = (DUMP_CLEAR != 0) && beat_take && (drain_ch == CH_W'(i));
    end
  end

  // Drain mux; beat payload reads as zero outside a drain.
  always_comb begin
    out_data = '0;
    out_ovf  = 1'b0;
    if (state == DRAIN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (drain_ch == CH_W'(i)) begin
          out_data = acc[i];
          out_ovf  = ovf_sticky[i];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .Rst     (Rst),
      .add_en  (add_sel[g]),
      .ld_en   (ld_sel[g]),
      .clr_en  (clr_sel[g]),
      .in_data (in_data),
      .ld_data (ld_data),
      .acc     (acc[g]),
      .ovf     (ovf_sticky[g])
    );
  end

endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank
//  Directed bench for accum_bank (default parameters). Inputs are driven and
//  outputs observed on the falling clock edge. A small reference model tracks
//  every channel; starting a drain pushes the expected beats onto a queue that
//  is popped as the DUT hands beats over.
//  Honours ACCUM_SATURATE_EN for the expected add result.
module tb_accum_bank;

  localparam int IN_W     = 4;
  localparam int ACC_W    = 16;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  logic                clk;
  logic                Rst;
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_ch;
  logic [IN_W-1:0]     in_data;
  logic                ld_en;
  logic [ACC_W-1:0]    ld_data;
  logic                dump_req;
  logic                dump_busy;
  logic                out_valid;
  logic                out_ready;
  logic [CH_W-1:0]     out_ch;
  logic [ACC_W-1:0]    out_data;
  logic                out_ovf;
  logic [CHANNELS-1:0] ovf_sticky;

  accum_bank #(
    .IN_W       (IN_W),
    .ACC_W      (ACC_W),
    .CHANNELS   (CHANNELS),
    .DUMP_CLEAR (1)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .ld_en      (ld_en),
    .ld_data    (ld_data),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky)
  );

  typedef struct {
    int               ch;
    logic [ACC_W-1:0] data;
    logic             ovf;
  } beat_t;

  int               tests_run    = 0;
  int               tests_failed = 0;
  beat_t            exp_q[$];
  logic [ACC_W-1:0] mdl_acc [CHANNELS];
  logic             mdl_ovf [CHANNELS];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model helpers.
  task automatic modelClear();
    for (int i = 0; i < CHANNELS; i++) begin
      mdl_acc[i] = '0;
      mdl_ovf[i] = 1'b0;
    end
  endtask

  task automatic modelAdd(input int ch, input logic [IN_W-1:0] d);
    logic [ACC_W:0] s;
    s = {1'b0, mdl_acc[ch]} + {13'd0, d};
    if (s[ACC_W]) begin
      mdl_ovf[ch] = 1'b1;
`ifdef ACCUM_SATURATE_EN
      mdl_acc[ch] = {ACC_W{1'b1}};
`else
      mdl_acc[ch] = s[ACC_W-1:0];
`endif
    end else begin
      mdl_acc[ch] = s[ACC_W-1:0];
    end
  endtask

  // Expected drain: every channel in order, then the bank is cleared.
  task automatic pushBeats();
    beat_t b;
    for (int i = 0; i < CHANNELS; i++) begin
      b.ch   = i;
      b.data = mdl_acc[i];
      b.ovf  = mdl_ovf[i];
      exp_q.push_back(b);
    end
    modelClear();
  endtask

  // One request cycle: optional sample/load plus optional dump_req.
  task automatic applyStimulus(input logic valid, input int ch, input logic [IN_W-1:0] d,
                               input logic ld, input logic [ACC_W-1:0] ldv, input logic dump);
    @(negedge clk);
    in_valid = valid;
    in_ch    = CH_W'(ch);
    in_data  = d;
    ld_en    = ld;
    ld_data  = ldv;
    dump_req = dump;
    if (valid) begin
      if (ld) begin
        mdl_acc[ch] = ldv;
        mdl_ovf[ch] = 1'b0;
      end else begin
        modelAdd(ch, d);
      end
    end
    if (dump) pushBeats();
    @(negedge clk);
    in_valid = 1'b0;
    ld_en    = 1'b0;
    dump_req = 1'b0;
  endtask

  // Consume a drain with out_ready toggling 1/0; optionally hammer the input
  // side and dump_req, which the DUT must ignore while draining.
  task automatic runDrain(input bit noise);
    int cyc;
    bit rdy;
    cyc = 0;
    rdy = 1'b1;
    while (exp_q.size() > 0 && cyc < 100) begin
      checkOutput("out_valid_in_drain", 32'(out_valid), 32'd1);
      checkOutput("busy_in_drain", 32'(dump_busy), 32'd1);
      checkOutput("in_ready_in_drain", 32'(in_ready), 32'd0);
      checkOutput("beat_ch", 32'(out_ch), 32'(exp_q[0].ch));
      checkOutput("beat_data", 32'(out_data), 32'(exp_q[0].data));
      checkOutput("beat_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
      out_ready = rdy;
      if (noise) begin
        in_valid = 1'b1;
        in_ch    = '0;
        in_data  = 4'hF;
        ld_en    = 1'b0;
        dump_req = 1'b1;
      end
      if (out_valid && rdy) void'(exp_q.pop_front());
      rdy = !rdy;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    dump_req  = 1'b0;
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout_beats_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    checkOutput("drain_end_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_end_busy", 32'(dump_busy), 32'd0);
    checkOutput("drain_end_ready", 32'(in_ready), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    ld_en     = 1'b0;
    ld_data   = '0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    modelClear();
    @(negedge clk);
    @(negedge clk);
    Rst = 1'b0;

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_dump_busy", 32'(dump_busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);

    // ch0 = 3+5+7+15 = 30, no overflow anywhere.
    applyStimulus(1, 0, 4'd3, 0, '0, 0);
    applyStimulus(1, 0, 4'd5, 0, '0, 0);
    applyStimulus(1, 0, 4'd7, 0, '0, 0);
    applyStimulus(1, 0, 4'd15, 0, '0, 0);
    checkOutput("sum30_ovf_sticky", 32'(ovf_sticky), 32'd0);
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(0);

    // Overflow on ch1: 0xFFFE + 3.
    applyStimulus(1, 1, '0, 1, 16'hFFFE, 0);
    applyStimulus(1, 1, 4'd3, 0, '0, 0);
    checkOutput("ovf1_sticky_set", 32'(ovf_sticky), 32'h2);
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(0);
    checkOutput("ovf_cleared_by_drain", 32'(ovf_sticky), 32'd0);

    // Overflow again, then a load clears the sticky flag.
    applyStimulus(1, 1, '0, 1, 16'hFFFF, 0);
    applyStimulus(1, 1, 4'd1, 0, '0, 0);
    checkOutput("ovf1_sticky_set_again", 32'(ovf_sticky), 32'h2);
    applyStimulus(1, 1, '0, 1, 16'h0010, 0);
    checkOutput("ovf1_cleared_by_load", 32'(ovf_sticky), 32'd0);
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(0);

    // Fill 1,2,3,4; drain with stalls while input and dump_req are hammered.
    for (int i = 0; i < CHANNELS; i++) applyStimulus(1, i, 4'(i + 1), 0, '0, 0);
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(1);
    // Cleared bank: a second drain must read all zeros.
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(0);

    // Add in the same cycle as dump_req: drain must see 3 + 9 on ch2.
    applyStimulus(1, 2, 4'd3, 0, '0, 0);
    applyStimulus(1, 2, 4'd9, 0, '0, 1);
    runDrain(0);

    // Reset in the middle of a drain, on the ch1 beat.
    for (int i = 0; i < CHANNELS; i++) applyStimulus(1, i, 4'(i + 5), 0, '0, 0);
    applyStimulus(0, 0, '0, 0, '0, 1);
    checkOutput("mid_beat0_ch", 32'(out_ch), 32'd0);
    checkOutput("mid_beat0_data", 32'(out_data), 32'(exp_q[0].data));
    out_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    checkOutput("mid_beat1_ch", 32'(out_ch), 32'd1);
    checkOutput("mid_beat1_data", 32'(out_data), 32'(exp_q[0].data));
    out_ready = 1'b0;
    Rst       = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    exp_q.delete();
    modelClear();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(dump_busy), 32'd0);
    checkOutput("midrst_out_ch", 32'(out_ch), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    applyStimulus(0, 0, '0, 0, '0, 1);
    runDrain(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
